// File: rtl/fpu8_op_sequencer.sv
// fpu8_op_sequencer: arbitrates two requesters onto the shared 8-bit FPU,
// pre-screens each op through the exception checker and returns one response.
module fpu8_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  NAN_VALUE      = 8'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [1:0] exc_op,
  output logic [7:0] exc_a,
  output logic [7:0] exc_b,
  input  logic       exc_flag,
  output logic       fpu_start,
  output logic [1:0] fpu_op,
  output logic [7:0] fpu_a,
  output logic [7:0] fpu_b,
  input  logic       fpu_done,
  input  logic [7:0] fpu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic [1:0] rsp_status
);

  // Op codes shared with the FPU core and exception checker.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_EXC     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_UNSUP   = 2'b11;

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fpu_start_q, fpu_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [7:0]       rsp_result_q, rsp_result_d;
  logic [1:0]       rsp_status_q, rsp_status_d;

  logic op_ok;
  logic grant1;
  logic accept;

  assign op_ok = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);

  assign exc_op     = op_q;
  assign exc_a      = a_q;
  assign exc_b      = b_q;
  assign fpu_op     = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign fpu_start  = fpu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_status = rsp_status_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a late DONE only matters while in WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req0_valid || req1_valid) state_d = S_CHECK;
      S_CHECK: if (!op_ok || exc_flag) state_d = S_RESP;
               else                    state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (fpu_done || (cnt_q == CNT_LAST)) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values: round-robin grant, latches, counter, response.
  always_comb begin
    grant1       = req1_valid && (!req0_valid || !last_q);
    accept       = (state_q == S_IDLE) && rst_n && (req0_valid || req1_valid);
    req0_ready   = accept && !grant1;
    req1_ready   = accept && grant1;
    last_d       = last_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    fpu_start_d  = (state_d == S_ISSUE);
    rsp_valid_d  = (state_d == S_RESP);
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;

    if (accept) begin
      last_d = grant1;
      id_d   = grant1;
      op_d   = grant1 ? req1_op : req0_op;
      a_d    = grant1 ? req1_a  : req0_a;
      b_d    = grant1 ? req1_b  : req0_b;
    end

    if (state_q == S_ISSUE)                 cnt_d = '0;
    else if (state_q == S_WAIT && !fpu_done) cnt_d = cnt_q + CNT_W'(1);

    if (state_q == S_CHECK && state_d == S_RESP) begin
      rsp_id_d     = id_q;
      rsp_result_d = NAN_VALUE;
      rsp_status_d = op_ok ? ST_EXC : ST_UNSUP;
    end
    if (state_q == S_WAIT && state_d == S_RESP) begin
      rsp_id_d     = id_q;
      rsp_result_d = fpu_done ? fpu_result : NAN_VALUE;
      rsp_status_d = fpu_done ? ST_OK : ST_TIMEOUT;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      fpu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else begin
      last_q       <= last_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      fpu_start_q  <= fpu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
    end
  end

endmodule

// File: tb/tb_fpu8_op_sequencer.sv
// Bench for fpu8_op_sequencer: directed scenarios then random ops against a
// transaction-level model (grant, status, result and latency per op).
module tb_fpu8_op_sequencer;

  localparam int unsigned T = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] exc_op;
  logic [7:0] exc_a, exc_b;
  logic       exc_flag;
  logic       fpu_start;
  logic [1:0] fpu_op;
  logic [7:0] fpu_a, fpu_b;
  logic       fpu_done;
  logic [7:0] fpu_result;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic [1:0] rsp_status;

  logic       rq_v  [2];
  logic [1:0] rq_op [2];
  logic [7:0] rq_a  [2];
  logic [7:0] rq_b  [2];

  int total = 0;
  int bad   = 0;
  int last_m;

  assign req0_valid = rq_v[0];
  assign req0_op    = rq_op[0];
  assign req0_a     = rq_a[0];
  assign req0_b     = rq_b[0];
  assign req1_valid = rq_v[1];
  assign req1_op    = rq_op[1];
  assign req1_a     = rq_a[1];
  assign req1_b     = rq_b[1];

  fpu8_op_sequencer #(.TIMEOUT_CYCLES(T), .NAN_VALUE(8'h7F)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .exc_op(exc_op), .exc_a(exc_a), .exc_b(exc_b), .exc_flag(exc_flag),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_status(rsp_status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    rq_v[p] = v; rq_op[p] = op; rq_a[p] = a; rq_b[p] = b;
  endtask

  // One complete transaction; called at a negedge with the DUT idle and requests presented.
  task automatic one_op(input logic exc, input int done_lat, input logic [7:0] res,
                        input int hold, input logic late);
    int g;
    int nwait;
    logic [1:0] eop;
    logic [7:0] ea, eb, eres;
    logic [1:0] est;
    #1;
    if (rq_v[0] && rq_v[1]) g = (last_m == 0) ? 1 : 0;
    else if (rq_v[0])       g = 0;
    else                    g = 1;
    chk("accept_ready0", 8'(req0_ready), 8'(g == 0));
    chk("accept_ready1", 8'(req1_ready), 8'(g == 1));
    last_m = g;
    eop = rq_op[g]; ea = rq_a[g]; eb = rq_b[g];

    @(negedge clk);
    rq_v[g]  = 1'b0;
    exc_flag = exc;
    #1;
    chk("check_ready0", 8'(req0_ready), 8'h00);
    chk("check_ready1", 8'(req1_ready), 8'h00);
    chk("exc_op", 8'(exc_op), 8'(eop));
    chk("exc_a", exc_a, ea);
    chk("exc_b", exc_b, eb);
    chk("fpu_op", 8'(fpu_op), 8'(eop));
    chk("check_start", 8'(fpu_start), 8'h00);

    @(negedge clk);
    exc_flag = 1'b0;
    #1;
    if (eop == 2'b11 || exc) begin
      est  = (eop == 2'b11) ? 2'b11 : 2'b01;
      eres = 8'h7F;
      chk("early_rsp_valid", 8'(rsp_valid), 8'h01);
      chk("early_no_start", 8'(fpu_start), 8'h00);
    end else begin
      chk("issue_start", 8'(fpu_start), 8'h01);
      chk("issue_rsp_valid", 8'(rsp_valid), 8'h00);
      if (done_lat < int'(T)) begin
        nwait = done_lat + 1; est = 2'b00; eres = res;
      end else begin
        nwait = int'(T); est = 2'b10; eres = 8'h7F;
      end
      for (int w = 0; w < nwait; w++) begin
        @(negedge clk);
        fpu_done   = (w == done_lat);
        fpu_result = (w == done_lat) ? res : 8'h00;
        #1;
        chk("wait_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("wait_start", 8'(fpu_start), 8'h00);
        chk("wait_fpu_a", fpu_a, ea);
        chk("wait_fpu_b", fpu_b, eb);
      end
      @(negedge clk);
      fpu_done   = late;
      fpu_result = 8'hAA;
      #1;
      chk("rsp_valid", 8'(rsp_valid), 8'h01);
    end
    chk("rsp_id", 8'(rsp_id), 8'(g));
    chk("rsp_status", 8'(rsp_status), 8'(est));
    chk("rsp_result", rsp_result, eres);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      fpu_done = 1'b0;
      #1;
      chk("hold_valid", 8'(rsp_valid), 8'h01);
      chk("hold_id", 8'(rsp_id), 8'(g));
      chk("hold_status", 8'(rsp_status), 8'(est));
      chk("hold_result", rsp_result, eres);
      chk("hold_ready0", 8'(req0_ready), 8'h00);
      chk("hold_ready1", 8'(req1_ready), 8'h00);
    end

    @(negedge clk);
    fpu_done  = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("final_valid", 8'(rsp_valid), 8'h01);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("idle_rsp_valid", 8'(rsp_valid), 8'h00);
  endtask

  initial begin
    int mask;
    rst_n = 1'b0; exc_flag = 1'b0; fpu_done = 1'b0; fpu_result = 8'h00; rsp_ready = 1'b0;
    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
    last_m = 1;
    #1;
    chk("rst_rsp_valid", 8'(rsp_valid), 8'h00);
    chk("rst_start", 8'(fpu_start), 8'h00);
    chk("rst_ready0", 8'(req0_ready), 8'h00);
    chk("rst_fpu_a", fpu_a, 8'h00);
    chk("rst_exc_op", 8'(exc_op), 8'h00);
    chk("rst_status", 8'(rsp_status), 8'h00);
    chk("rst_result", rsp_result, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single add: DONE one cycle after the first WAIT cycle.
    @(negedge clk);
    set_req(0, 1'b1, 2'b00, 8'h38, 8'h38);
    one_op(1'b0, 1, 8'h40, 0, 1'b0);

    // Exception and unsupported-op screening.
    set_req(0, 1'b1, 2'b01, 8'h12, 8'h34);
    one_op(1'b1, 0, 8'h00, 1, 1'b0);
    set_req(1, 1'b1, 2'b11, 8'h56, 8'h78);
    one_op(1'b1, 0, 8'h00, 0, 1'b0);

    // Timeout with a late DONE, then DONE exactly at expiry.
    set_req(0, 1'b1, 2'b10, 8'h3C, 8'h40);
    one_op(1'b0, 99, 8'h00, 2, 1'b1);
    set_req(1, 1'b1, 2'b00, 8'h21, 8'h22);
    one_op(1'b0, int'(T) - 1, 8'h5A, 0, 1'b0);

    // Backpressure with the other port waiting; it must win the very next cycle.
    set_req(0, 1'b1, 2'b01, 8'h44, 8'h11);
    set_req(1, 1'b1, 2'b10, 8'h66, 8'h22);
    one_op(1'b0, 0, 8'hC3, 10, 1'b0);
    one_op(1'b0, 2, 8'h9E, 0, 1'b0);

    // Reset pulse during WAIT aborts the op.
    set_req(0, 1'b1, 2'b00, 8'hA1, 8'hB2);
    #1;
    chk("pre_rst_ready0", 8'(req0_ready), 8'h01);
    @(negedge clk); rq_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rq_v[1] = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("midrst_rsp_valid", 8'(rsp_valid), 8'h00);
    chk("midrst_start", 8'(fpu_start), 8'h00);
    chk("midrst_ready1", 8'(req1_ready), 8'h00);
    chk("midrst_fpu_a", fpu_a, 8'h00);
    chk("midrst_status", 8'(rsp_status), 8'h00);
    last_m = 1;
    @(negedge clk);
    set_req(0, 1'b1, 2'b00, 8'h10, 8'h20);
    set_req(1, 1'b1, 2'b01, 8'h30, 8'h40);
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports continuously valid: grants must alternate starting at port 0.
    for (int k = 0; k < 4; k++) begin
      one_op(1'b0, k, 8'(8'h50 + k), 0, 1'b0);
      if (!rq_v[0]) set_req(0, 1'b1, 2'b10, 8'(k), 8'(k + 1));
      if (!rq_v[1]) set_req(1, 1'b1, 2'b00, 8'(k + 8), 8'(k + 9));
    end

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      mask = int'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++)
        set_req(p, mask[p], ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                8'($urandom), 8'($urandom));
      one_op($urandom_range(0, 3) == 0, int'($urandom_range(0, 5)), 8'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    set_req(0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1, 1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
